// File: rtl/muldiv_controller_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Exports: state_t, XLEN_DEF, DIV_ZERO_QUOTIENT.
package muldivPkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FIXUP
  } state_t;

  localparam logic [XLEN_DEF-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_controller_div_step.sv
// One restoring-divide iteration, purely combinational.
// Ports: rem/quo/div in; rem_next/quo_next out.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] div,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0]   shifted;
  logic [W-1:0] trial;
  logic         fits;

  // A fitting difference is < div, so W-bit wrap is exact.
  always_comb begin
    shifted  = {rem, quo[W-1]};
    fits     = shifted >= {1'b0, div};
    trial    = shifted[W-1:0] - div;
    rem_next = fits ? trial : shifted[W-1:0];
    quo_next = {quo[W-2:0], fits};
  end

endmodule

// File: rtl/muldiv_controller.sv
// Execute-stage mul/div sequencer owning the HI/LO registers.
// Ports: clk, rst (async low), request flags, opA/opB; stall, busy, mvResult, hi, lo.
module muldiv_controller
  import muldivPkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int XLEN        = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  input  logic            isMult,
  input  logic            isMultSigned,
  input  logic            isDiv,
  input  logic            isDivSigned,
  input  logic            isMVHI,
  input  logic            isMVLO,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] mvResult,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int LW = $clog2(XLEN);
  localparam int CW = (LW > 4) ? LW : 4;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] rem_q;
  logic            mul_signed;
  logic            neg_q;
  logic            neg_r;

  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;

  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] prod;

  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  div_step #(
    .W(XLEN)
  ) u_step (
    .rem      (rem_q),
    .quo      (opa_q),
    .div      (opb_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Sign-extending to the full product width makes the low
  // 2*XLEN bits of an unsigned multiply equal the signed one.
  always_comb begin
    mul_a = {{XLEN{mul_signed & opa_q[XLEN-1]}}, opa_q};
    mul_b = {{XLEN{mul_signed & opb_q[XLEN-1]}}, opb_q};
    prod  = mul_a * mul_b;
  end

  always_comb begin
    sign_a = isDivSigned & opA[XLEN-1];
    sign_b = isDivSigned & opB[XLEN-1];
    mag_a  = sign_a ? (~opA + 1'b1) : opA;
    mag_b  = sign_b ? (~opB + 1'b1) : opB;
  end

  assign stall = reqValid
               & (isMult | isDiv | isMVHI | isMVLO)
               & (state != IDLE);

  always_comb begin
    mvResult = '0;
    if (state == IDLE && reqValid) begin
      if (isMVHI)
        mvResult = hi;
      else if (isMVLO)
        mvResult = lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      rem_q      <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      busy       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (reqValid && isMult) begin
            opa_q      <= opA;
            opb_q      <= opB;
            mul_signed <= isMultSigned;
            cnt        <= CW'(MULT_CYCLES - 1);
            busy       <= 1'b1;
            state      <= MULT;
          end else if (reqValid && isDiv) begin
            busy <= 1'b1;
            if (opB == '0) begin
              // Skip iteration; FIXUP writes the fixed result.
              opa_q <= {XLEN{DIV_ZERO_QUOTIENT[0]}};
              rem_q <= opA;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FIXUP;
            end else begin
              opa_q <= mag_a;
              opb_q <= mag_b;
              rem_q <= '0;
              neg_q <= sign_a ^ sign_b;
              neg_r <= sign_a;
              cnt   <= CW'(XLEN - 1);
              state <= DIV;
            end
          end
        end
        MULT: begin
          if (cnt == '0) begin
            hi    <= prod[2*XLEN-1:XLEN];
            lo    <= prod[XLEN-1:0];
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          rem_q <= rem_nx;
          opa_q <= quo_nx;
          if (cnt == '0)
            state <= FIXUP;
          else
            cnt <= cnt - 1'b1;
        end
        FIXUP: begin
          lo    <= neg_q ? (~opa_q + 1'b1) : opa_q;
          hi    <= neg_r ? (~rem_q + 1'b1) : rem_q;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Randomized + directed bench for muldiv_controller.
// A cycle-count/arithmetic model predicts busy, stall, mvResult, hi, lo.
module tb_muldiv_controller;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0;
  logic        isMult = 1'b0;
  logic        isMultSigned = 1'b0;
  logic        isDiv = 1'b0;
  logic        isDivSigned = 1'b0;
  logic        isMVHI = 1'b0;
  logic        isMVLO = 1'b0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        stall;
  logic        busy;
  logic [31:0] mvResult;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  muldiv_controller #(
    .MULT_CYCLES(MC),
    .XLEN(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reqValid     (reqValid),
    .isMult       (isMult),
    .isMultSigned (isMultSigned),
    .isDiv        (isDiv),
    .isDivSigned  (isDivSigned),
    .isMVHI       (isMVHI),
    .isMVLO       (isMVLO),
    .opA          (opA),
    .opB          (opB),
    .stall        (stall),
    .busy         (busy),
    .mvResult     (mvResult),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  int          m_rem = 0;

  function automatic logic [63:0] mul_ref(bit s, logic [31:0] a, logic [31:0] b);
    longint x;
    longint y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    return 64'(x * y);
  endfunction

  function automatic logic [63:0] div_ref(bit s, logic [31:0] a, logic [31:0] b);
    longint x;
    longint y;
    longint q;
    longint r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic bit exp_stall();
    return reqValid && (isMult || isDiv || isMVHI || isMVLO) && (m_rem != 0);
  endfunction

  function automatic logic [31:0] exp_mv();
    if (m_rem != 0 || !reqValid) return 32'h0;
    if (isMVHI) return m_hi;
    if (isMVLO) return m_lo;
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hi  <= '0;
      m_lo  <= '0;
      m_rem <= 0;
    end else if (m_rem != 0) begin
      if (m_rem == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
      m_rem <= m_rem - 1;
    end else if (reqValid && isMult) begin
      {p_hi, p_lo} <= mul_ref(isMultSigned, opA, opB);
      m_rem <= MC;
    end else if (reqValid && isDiv) begin
      {p_hi, p_lo} <= div_ref(isDivSigned, opA, opB);
      m_rem <= (opB == 0) ? 1 : 33;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_rem != 0});
      chk("stall", {31'b0, stall}, {31'b0, exp_stall()});
      chk("mvResult", mvResult, exp_mv());
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  localparam int OP_MLTU = 0;
  localparam int OP_MLTS = 1;
  localparam int OP_DIVU = 2;
  localparam int OP_DIVS = 3;
  localparam int OP_MVHI = 4;
  localparam int OP_MVLO = 5;
  localparam int OP_NOP  = 6;
  localparam int OP_OFF  = 7;

  task automatic set_req(int op, logic [31:0] a, logic [31:0] b);
    reqValid     = (op != OP_OFF);
    isMult       = (op == OP_MLTU) || (op == OP_MLTS);
    isMultSigned = (op == OP_MLTS);
    isDiv        = (op == OP_DIVU) || (op == OP_DIVS);
    isDivSigned  = (op == OP_DIVS);
    isMVHI       = (op == OP_MVHI);
    isMVLO       = (op == OP_MVLO);
    if (op == OP_OFF) begin
      case ($urandom_range(0, 3))
        0: isMult = 1'b1;
        1: isDiv  = 1'b1;
        2: isMVHI = 1'b1;
        default: isMVLO = 1'b1;
      endcase
    end
    opA = a;
    opB = b;
  endtask

  task automatic clr_req();
    reqValid = 0; isMult = 0; isMultSigned = 0; isDiv = 0;
    isDivSigned = 0; isMVHI = 0; isMVLO = 0;
  endtask

  // Present a request and hold it while stalled; returns
  // just after the accepting edge with the request dropped.
  task automatic issue(int op, logic [31:0] a, logic [31:0] b);
    bit ok;
    ok = 0;
    @(posedge clk); #2;
    set_req(op, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!exp_stall()) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL issue_timeout op=%0d", op);
    end
    @(posedge clk); #2;
    clr_req();
  endtask

  task automatic busy_len(string name, int exp);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk(name, 32'(n), 32'(exp));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_rem == 0) break;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int sc;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    issue(OP_MLTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_len("mltu_busy_len", MC);
    chk("mltu_hi", hi, 32'hFFFF_FFFE);
    chk("mltu_lo", lo, 32'h0000_0001);

    issue(OP_MLTS, 32'hFFFF_FFFD, 32'd7);
    busy_len("mlts_busy_len", MC);
    chk("mlts_hi", hi, 32'hFFFF_FFFF);
    chk("mlts_lo", lo, 32'hFFFF_FFEB);
    @(posedge clk); #2;
    set_req(OP_MVLO, '0, '0);
    @(negedge clk);
    chk("mvlo_idle", mvResult, 32'hFFFF_FFEB);
    @(posedge clk); #2;
    clr_req();

    issue(OP_DIVS, 32'hFFFF_FFF9, 32'd2);
    busy_len("divs_busy_len", 33);
    chk("divs_lo", lo, 32'hFFFF_FFFD);
    chk("divs_hi", hi, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'd100, 32'd7);
    busy_len("divu_busy_len", 33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    issue(OP_DIVU, 32'd5, 32'd0);
    busy_len("div0_busy_len", 1);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);

    issue(OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len("intmin_busy_len", 33);
    chk("intmin_lo", lo, 32'h8000_0000);
    chk("intmin_hi", hi, 32'h0);

    // MVHI held across a divide
    issue(OP_DIVU, 32'd1000, 32'd3);
    set_req(OP_MVHI, '0, '0);
    sc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (stall) sc++;
      else break;
    end
    chk("mvhi_stall_cycles", 32'(sc), 32'd33);
    chk("mvhi_new_hi", mvResult, 32'd1);
    @(posedge clk); #2;
    clr_req();

    // MLTU held across a signed divide
    issue(OP_DIVS, 32'hFFFF_FF9C, 32'd7);
    issue(OP_MLTU, 32'd6, 32'd7);
    chk("div_before_mul_lo", lo, 32'hFFFF_FFF2);
    chk("div_before_mul_hi", hi, 32'hFFFF_FFFE);
    wait_idle();
    chk("held_mltu_lo", lo, 32'd42);
    chk("held_mltu_hi", hi, 32'd0);

    // reset in the middle of a divide
    issue(OP_DIVU, 32'd77, 32'd5);
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    set_req(OP_MVLO, '0, '0);
    @(negedge clk);
    chk("rst_mvlo", mvResult, 32'h0);
    @(posedge clk); #2;
    clr_req();

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      issue(int'($urandom_range(0, 7)), pick(), pick());
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_controller.md
Name: muldiv_controller

Overview:
Sequencer for the shared multiply/divide resource driven by the decoder's isMult/isMultSigned/isDiv/isDivSigned/isMVHI/isMVLO signals. It accepts one MLT/DIV operation at a time, runs a fixed-latency multiply or an iterative radix-2 divide, and owns the HI/LO result registers. While busy it stalls the pipeline for any new mul/div or MVHI/MVLO request. It sits in the execute stage beside the ALU.

Parameters:
MULT_CYCLES, 4, cycles the multiply occupies the unit (1..15)
XLEN, 32, operand and HI/LO width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
reqValid  in  1  execute-stage instruction valid and condition passed
isMult  in  1  MLTU/MLTS request
isMultSigned  in  1  signed multiply
isDiv  in  1  DIVU/DIVS request
isDivSigned  in  1  signed divide
isMVHI  in  1  read HI request
isMVLO  in  1  read LO request
opA  in  XLEN  multiplicand / dividend
opB  in  XLEN  multiplier / divisor
stall  out  1  hold the execute stage this cycle
busy  out  1  operation in flight
mvResult  out  XLEN  HI or LO for MVHI/MVLO
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- Reset (rst=0, async): state IDLE, hi=lo=0, busy=0, stall=0, counters cleared. Reset mid-operation aborts the operation; no partial result is kept.
- States: IDLE, MULT, DIV, FIXUP.
- IDLE + reqValid&isMult: latch operands/sign, counter=MULT_CYCLES-1, go MULT. stall=0 this cycle (request accepted).
- MULT: busy=1; decrement counter; at counter=0 write {hi,lo}=64-bit product (sign-extended 33x33 if signed, else zero-extended), go IDLE. busy is high for exactly MULT_CYCLES cycles.
- IDLE + reqValid&isDiv: latch |opA|, |opB| (magnitudes if signed, raw if unsigned), record quotient sign = signA^signB, remainder sign = signA, count=31, go DIV.
- DIV: one restoring step per cycle (shift remainder/quotient left 1, subtract divisor if no borrow); 32 cycles, then FIXUP.
- FIXUP: apply signs (two's-complement negate where recorded), write lo=quotient, hi=remainder, go IDLE. Divide busy = 33 cycles (32 DIV + 1 FIXUP).
- Signed results truncate toward zero; remainder takes the dividend's sign.
- Divide by zero (opB=0): no iteration; next cycle lo=all ones, hi=opA; busy for 1 cycle.
- Signed INT_MIN / -1: lo=0x80000000, hi=0 (falls out of unsigned magnitude path; no trap).
- stall = reqValid & (isMult|isDiv|isMVHI|isMVLO) & (state != IDLE). A stalled request is not accepted; the upstream holds it until stall=0.
- MVHI/MVLO in IDLE: mvResult = hi or lo combinationally, same cycle. Otherwise mvResult=0.
- The cycle the unit returns to IDLE it accepts a new request; hi/lo are already updated, so an MVLO presented in that cycle reads the new value.
- Only one of the request flags is active per cycle, as guaranteed by the decoder. With reqValid=0 all flags are ignored.
- An accepted operation always completes and is never cancelled except by reset.
- hi/lo change only at completion of MULT, FIXUP or div-by-zero.

Decomposition:
- Package muldivPkg: state enum (IDLE, MULT, DIV, FIXUP), DIV_ZERO_QUOTIENT = all ones, XLEN default.
- Sub-module div_step: combinational single restoring-divide iteration (remainder, quotient, divisor in; next remainder, quotient out), instantiated once inside muldiv_controller.

Test Plan:
- MLTU 0xFFFFFFFF x 0xFFFFFFFF -> after 4 cycles hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 4 cycles.
- MLTS -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MVLO in IDLE -> mvResult=0xFFFFFFEB same cycle.
- DIVS -7 / 2 -> after 33 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU 5 / 0 -> next cycle lo=0xFFFFFFFF, hi=5; DIVS 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MVHI and a second MLTU issued during a divide -> stall=1 every busy cycle. In the IDLE cycle stall=0, MVHI returns the new hi, and the MLTU is accepted.
- rst=0 at divide cycle 10 -> hi=lo=0, busy=0 immediately. After release, MVLO returns 0.
